// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup datapath: default operand widths
// and the state encoding of the Montgomery-constant (modular inverse) unit.
package rsa_pkg;

    // Default modulus width and Montgomery word width.
    localparam int RSA_N_WIDTH = 4096;
    localparam int MONT_W      = 32;

    // Controller states of the inverse unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } modinv_state_t;

endpackage

// File: rtl/modinv_pow2.sv
// Inverse of an odd modulus modulo 2^W, optionally negated, computed by
// bit-serial Hensel lifting: one result bit per clock, no multiplier or
// divider. The result feeds the Montgomery multiplier as its n' constant.
module modinv_pow2
    import rsa_pkg::*;
#(
    parameter int N_WIDTH = RSA_N_WIDTH,
    parameter int W       = MONT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [N_WIDTH-1:0] n,
    input  logic               neg,
    output logic [W-1:0]       modulo_inv,
    output logic               valid,
    output logic               err,
    output logic               busy
);

    // Bit index runs 1 .. W-1, so $clog2(W) bits are enough.
    localparam int            IW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(W - 1);

    modinv_state_t state_reg;
    logic [W-1:0]  n0_reg;      // low W bits of the captured modulus
    logic          neg_reg;     // captured output mode
    logic [W-1:0]  y_reg;       // inverse under construction
    logic [W-1:0]  p_reg;       // n0 * y mod 2^W, kept incrementally
    logic [IW-1:0] i_reg;       // bit currently being resolved
    logic [W-1:0]  inv_reg;
    logic          valid_reg;
    logic          err_reg;
    logic          busy_reg;

    logic [W-1:0]  p_next;
    logic          fix_bit;

    // Only the low W bits of the modulus matter; the rest is ignored.
    generate
        if (W < N_WIDTH) begin : g_high_bits
            logic unused_high_bits;
            assign unused_high_bits = ^n[N_WIDTH-1:W];
        end
    endgenerate

    // Lifting step: if bit i of the running product is set, adding n0<<i
    // clears it (n0 is odd) and setting y[i] keeps p = n0*y.
    always_comb begin
        fix_bit = p_reg[i_reg];
        p_next  = p_reg + (n0_reg << i_reg);
    end

    // Controller and datapath registers; go restarts from any state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            n0_reg    <= '0;
            neg_reg   <= 1'b0;
            y_reg     <= '0;
            p_reg     <= '0;
            i_reg     <= '0;
            inv_reg   <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (go) begin
            n0_reg    <= n[W-1:0];
            neg_reg   <= neg;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            y_reg     <= W'(1);
            p_reg     <= n[W-1:0];
            i_reg     <= IW'(1);
            if (n[0]) begin
                busy_reg  <= 1'b1;
                state_reg <= ITER;
            end else begin
                // Even modulus: no inverse, report it on the next edge.
                busy_reg  <= 1'b0;
                state_reg <= FIN;
            end
        end else begin
            case (state_reg)
                ITER: begin
                    if (fix_bit) begin
                        y_reg[i_reg] <= 1'b1;
                        p_reg        <= p_next;
                    end
                    i_reg <= i_reg + IW'(1);
                    if (i_reg == I_LAST) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    if (n0_reg[0]) begin
                        inv_reg   <= neg_reg ? ({W{1'b0}} - y_reg) : y_reg;
                        valid_reg <= 1'b1;
                    end else begin
                        err_reg   <= 1'b1;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign modulo_inv = inv_reg;
    assign valid      = valid_reg;
    assign err        = err_reg;
    assign busy       = busy_reg;

endmodule
